slowio_uart: RTL
================

// Module: slowio_uart
// PURPOSE
//  8N1 UART that terminates the slow-IO toggle link on the device side. It is downstream of the
//  peripheral-bus slow-IO buffer. Bytes handed over by the write toggle are serialised onto tx.
//  Bytes deserialised from rx are published through the read toggle. Single clock domain; rx is async.
// PARAMETERS
//  BAUD_DIV    434  clock cycles per bit (50 MHz / 115200); legal range 4..2^DIV_WIDTH-1
//  DIV_WIDTH   16   width of the bit-period counters
// PORTS
//  clock              in   1  system clock
//  reset              in   1  synchronous, active-high
//  data_write         in   8  byte from the buffer; valid while a write request is pending
//  write_odd_request  in   1  request toggle; pending when != write_odd
//  write_odd          out  1  ack toggle; copies write_odd_request when the byte is accepted
//  data_read          out  8  last received byte; holds until the next delivery
//  read_odd           out  1  toggles once per delivered byte
//  try_stop_reading   in   1  buffer nearly full
//  rx                 in   1  serial input, idle high, asynchronous
//  tx                 out  1  serial output, idle high
//  rts_n              out  1  request-to-send, active low (see CONFIGURATION)
//  cts_n              in   1  clear-to-send, active low (see CONFIGURATION)
//  rx_overrun         out  1  one-cycle pulse: a byte was dropped because try_stop_reading=1
//  rx_frame_error     out  1  one-cycle pulse: a byte was dropped because its stop bit sampled low
// BEHAVIOUR
//  Reset values:
//   - tx=1, write_odd=0, read_odd=0, data_read=0, rx_overrun=0, rx_frame_error=0, rts_n=1.
//   - Both FSMs go to IDLE and all counters clear.
//   - Reset mid-frame aborts the frame. tx is high the cycle after reset is sampled.
//   - A partially received byte is discarded.
//  TX FSM (IDLE -> START -> DATA -> STOP -> IDLE):
//   - Accept: in IDLE with write_odd_request != write_odd (and the send gate open).
//     On that edge: latch data_write and set write_odd <= write_odd_request.
//   - tx drives 0 from the next cycle.
//   - Each bit lasts exactly BAUD_DIV cycles. Bits are sent LSB first.
//   - STOP drives tx=1 for BAUD_DIV cycles, then returns to IDLE.
//   - A request pending at the last STOP cycle is accepted in IDLE on the following cycle.
//     The inter-frame gap is therefore 1 cycle and the frame length is 10*BAUD_DIV+1 cycles.
//   - No other source changes write_odd. A request toggle that arrives mid-frame waits.
//  RX input path:
//   - rx passes through a 2-flop synchroniser. rx_s denotes the synchronised value.
//  RX FSM (IDLE -> START -> DATA -> STOP -> IDLE):
//   - IDLE: a 1->0 transition on rx_s moves to START and loads the counter with BAUD_DIV/2 (floor).
//   - START: at expiry, if rx_s=1 (glitch) return to IDLE with no output. Otherwise enter DATA.
//   - DATA: sample 8 bits, each BAUD_DIV cycles apart, mid-bit. Shift in LSB first.
//   - STOP: sample once, BAUD_DIV later.
//     - stop=0: drop the byte, pulse rx_frame_error, go to IDLE (the line must return high before the next start).
//     - stop=1, try_stop_reading=1: drop the byte, pulse rx_overrun.
//     - stop=1, try_stop_reading=0: on the same edge, data_read <= byte and read_odd <= ~read_odd.
//   - In all STOP cases, return to IDLE the next cycle.
//   - Delivery is fire-and-forget. The buffer latches on the toggle and there is no ack.
//  Independence: TX and RX run fully in parallel. A TX accept and an RX delivery in the same cycle are both legal.
//  Counters: the counter is DIV_WIDTH bits, counts down, and reloads to BAUD_DIV-1. There is no wrap hazard inside the legal range.
// CONFIGURATION
//  SLOWIO_UART_FLOW_CTRL_EN:
//   - Defined:
//     - rts_n is registered ~(~try_stop_reading), i.e. rts_n=1 while the buffer is nearly full.
//     - cts_n passes through a 2-flop synchroniser. TX accepts only while synchronised cts_n=0.
//     - A frame already started always completes.
//   - Undefined:
//     - rts_n is tied 0 after reset.
//     - cts_n is ignored; the send gate is always open.
//     - Overrun dropping still applies.
// TESTING
//  1. Use BAUD_DIV=8. Toggle write_odd_request with data_write=8'hA5. Required response:
//     - write_odd follows on the next edge.
//     - tx = 0,1,0,1,0,0,1,0,1,1, each level held 8 cycles.
//  2. Queue back-to-back requests 8'h00 and 8'hFF. Required response:
//     - The second accept occurs exactly 81 cycles after the first.
//     - write_odd toggles twice in total.
//  3. Drive rx with an 8'h3C frame at BAUD_DIV=8. Required response:
//     - read_odd toggles once and data_read=8'h3C.
//     - The delivery edge falls 2 sync cycles + 4 + 8*8 + 8 cycles after the start edge.
//  4. Drive rx with a 3-cycle low glitch -> no toggle and no pulses. Drive rx with the stop bit low -> rx_frame_error pulses once and read_odd is unchanged.
//  5. Hold try_stop_reading=1 during a received frame -> rx_overrun pulses once and read_odd/data_read are unchanged. With the FLOW_CTRL_EN macro defined, rts_n=1.
//  6. Assert reset mid-TX data bit and mid-RX frame. Required response:
//     - tx=1 the next cycle, write_odd=0, read_odd=0.
//     - A fresh request after reset is transmitted correctly.
//  7. With SLOWIO_UART_FLOW_CTRL_EN defined and cts_n=1, a pending request stays pending and tx stays idle. Lowering cts_n starts the frame within 3 cycles.

Source files
------------

// File: rtl/slowio_uart.sv
// 8N1 UART for the device end of the slow-IO toggle link. Optional flow control: SLOWIO_UART_FLOW_CTRL_EN.
// Latency: TX frame is 10*BAUD_DIV+1 cycles from accept; RX delivers 2+BAUD_DIV/2+9*BAUD_DIV cycles after start edge.
// Backpressure: TX request toggle waits while busy (or cts_n high); RX drops bytes when try_stop_reading is set.
module slowio_uart #(
    parameter int BAUD_DIV  = 434,
    parameter int DIV_WIDTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_write,
    input  logic       write_odd_request,
    output logic       write_odd,
    output logic [7:0] data_read,
    output logic       read_odd,
    input  logic       try_stop_reading,
    input  logic       rx,
    output logic       tx,
    output logic       rts_n,
    input  logic       cts_n,
    output logic       rx_overrun,
    output logic       rx_frame_error
);
    localparam logic [DIV_WIDTH-1:0] BIT_LAST  = DIV_WIDTH'(BAUD_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] HALF_LAST = DIV_WIDTH'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic send_open;
    logic rts_q;
`ifdef SLOWIO_UART_FLOW_CTRL_EN
    logic cts_meta, cts_s;
    always_ff @(posedge clock) begin
        if (reset) begin
            cts_meta <= 1'b1;
            cts_s    <= 1'b1;
            rts_q    <= 1'b1;
        end else begin
            cts_meta <= cts_n;
            cts_s    <= cts_meta;
            rts_q    <= try_stop_reading;
        end
    end
    assign send_open = ~cts_s;
`else
    logic unused_cts_n;
    assign unused_cts_n = cts_n;
    always_ff @(posedge clock) begin
        rts_q <= reset;
    end
    assign send_open = 1'b1;
`endif
    assign rts_n = rts_q;

    // ---------------- transmitter ----------------
    uart_state_t          tx_state, tx_state_nxt;
    logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]           tx_bit, tx_bit_nxt;
    logic [7:0]           tx_shift, tx_shift_nxt;
    logic                 tx_q, tx_nxt, wodd_q, wodd_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_q     <= 1'b1;
            wodd_q   <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            tx_q     <= tx_nxt;
            wodd_q   <= wodd_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_nxt       = tx_q;
        wodd_nxt     = wodd_q;
        case (tx_state)
            IDLE: begin
                if ((write_odd_request != wodd_q) && send_open) begin
                    tx_shift_nxt = data_write;
                    wodd_nxt     = write_odd_request;
                    tx_cnt_nxt   = BIT_LAST;
                    tx_nxt       = 1'b0;
                    tx_state_nxt = START;
                end
            end
            START: begin
                if (tx_cnt == '0) begin
                    tx_state_nxt = DATA;
                    tx_cnt_nxt   = BIT_LAST;
                    tx_bit_nxt   = 3'd0;
                    tx_nxt       = tx_shift[0];
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nxt = BIT_LAST;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = STOP;
                        tx_nxt       = 1'b1;
                    end else begin
                        tx_bit_nxt   = tx_bit + 3'd1;
                        tx_nxt       = tx_shift[0];
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt == '0) tx_state_nxt = IDLE;
                else              tx_cnt_nxt   = tx_cnt - 1'b1;
            end
            default: tx_state_nxt = IDLE;
        endcase
    end

    assign tx        = tx_q;
    assign write_odd = wodd_q;

    // ---------------- receiver ----------------
    logic                 rx_meta, rx_s, rx_s_d;
    uart_state_t          rx_state, rx_state_nxt;
    logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]           rx_bit, rx_bit_nxt;
    logic [7:0]           rx_shift, rx_shift_nxt;
    logic [7:0]           rdat_q, rdat_nxt;
    logic                 rodd_q, rodd_nxt, ovr_q, ovr_nxt, fe_q, fe_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_s_d   <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rdat_q   <= '0;
            rodd_q   <= 1'b0;
            ovr_q    <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            rx_s_d   <= rx_s;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            rdat_q   <= rdat_nxt;
            rodd_q   <= rodd_nxt;
            ovr_q    <= ovr_nxt;
            fe_q     <= fe_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rdat_nxt     = rdat_q;
        rodd_nxt     = rodd_q;
        ovr_nxt      = 1'b0;
        fe_nxt       = 1'b0;
        case (rx_state)
            IDLE: begin
                // The edge is seen one cycle after rx_s falls, so the half-bit wait is shortened by one.
                if (rx_s_d && !rx_s) begin
                    rx_state_nxt = START;
                    rx_cnt_nxt   = HALF_LAST;
                end
            end
            START: begin
                if (rx_cnt == '0) begin
                    rx_state_nxt = rx_s ? IDLE : DATA;
                    rx_cnt_nxt   = BIT_LAST;
                    rx_bit_nxt   = 3'd0;
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_nxt = {rx_s, rx_shift[7:1]};
                    rx_cnt_nxt   = BIT_LAST;
                    if (rx_bit == 3'd7) rx_state_nxt = STOP;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_nxt = IDLE;
                    if (!rx_s) begin
                        fe_nxt = 1'b1;
                    end else if (try_stop_reading) begin
                        ovr_nxt = 1'b1;
                    end else begin
                        rdat_nxt = rx_shift;
                        rodd_nxt = ~rodd_q;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            default: rx_state_nxt = IDLE;
        endcase
    end

    assign data_read      = rdat_q;
    assign read_odd       = rodd_q;
    assign rx_overrun     = ovr_q;
    assign rx_frame_error = fe_q;
endmodule
